alu_serial_seq: RTL
===================

Name: alu_serial_seq

Overview:
Bit-serial sequential ALU that uses the same 3-bit op encoding as the processor's combinational ALU slices. It latches a full-width operand pair and op code on a start handshake. It then processes one bit per clock, LSB first, with a registered carry, and returns a full-width result with carry, zero and overflow flags. It serves as the area-minimal multi-cycle ALU alternative for the single-cycle core, feeding the same flag consumers.

Parameters:
WIDTH, 32, operand/result width in bits; legal range 2..64
CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; not overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
op  input  3  000 add, 001 sub, 010 and, 100 or, 110 xor
a  input  WIDTH  operand A, latched on accepted start
b  input  WIDTH  operand B, latched on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when results become valid
result  output  WIDTH  registered result, held until next completion
carry_out  output  1  add: carry out of MSB; sub: no-borrow (1 when A>=B unsigned); logic ops: 0
zero_flag  output  1  1 when the whole result==0
overflow  output  1  add/sub: carry into MSB XOR carry out of MSB; logic ops: 0
op_err  output  1  1 when the last accepted op was an illegal encoding

Behaviour:
- Reset (async, rst_n=0): state=IDLE. busy, done, result, carry_out, zero_flag, overflow and op_err all =0. Internal shift registers, carry and counter =0. Reset mid-RUN aborts the operation silently, with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1: latch a, b and op. Carry init = 1 for sub, 0 otherwise. B is inverted bitwise for sub. Counter=0. Go to RUN.
- DONE with start=0: return to IDLE.
- done=1 only in the DONE state, so it lasts exactly one cycle.
- RUN, each cycle:
  - bit i = counter.
  - add/sub: sum = a_i^b'_i^c, c <= majority(a_i,b'_i,c).
  - and/or/xor: the bitwise function of a_i,b_i; carry unchanged.
  - The bit is shifted into the result register from the MSB side, so bit WIDTH-1 lands last and the final word is aligned.
  - Zero accumulator ORs in each bit.
  - Before processing bit WIDTH-1, the carry-in is captured for the overflow calculation.
  - counter++. After bit WIDTH-1 is processed, go to DONE.
- Latency: start sampled at edge 0. busy is high for exactly WIDTH cycles. done is high in cycle WIDTH+1. result and flags update on the same edge that raises done.
- Outputs hold their values through IDLE until the next done. They are not cleared by a new start.
- start while busy=1 is ignored: no queueing, and latched operands are unaffected.
- Illegal op (011, 101, 111) is accepted normally and runs the full WIDTH cycles. Then result=0, zero_flag=1, carry_out=0, overflow=0, op_err=1. op_err clears on the next legal completion.
- Sub arithmetic is two's complement, modulo 2^WIDTH. Examples: 0-1 = all-ones with carry_out=0. Add wraps with carry_out=1.
- Back-to-back: start=1 during DONE is accepted, giving a throughput of one op per WIDTH+1 cycles.

Optional Feature:
ALU_SERIAL_SLT_EN
- Defined: op 111 = signed set-less-than. Internally runs sub. result = {WIDTH-1 zeros, N^V}, where N is the sub MSB and V is the sub overflow. zero_flag reflects the final result. carry_out=0, overflow=0, op_err=0.
- Undefined: 111 is illegal and handled per the op_err rule above.
- Latency is identical in both builds.

Test Plan (WIDTH=8):
- Reset mid-run: rst_n low at the 3rd RUN cycle -> all outputs 0 immediately, no done pulse. A new start then completes normally.
- Add: a=8'hFF, b=8'h01 -> after 9 cycles: done pulse, result=8'h00, carry_out=1, zero_flag=1, overflow=0. busy high exactly 8 cycles.
- Sub: a=8'h80, b=8'h01 -> result=8'h7F, carry_out=1, overflow=1, zero_flag=0. Then a=8'h00, b=8'h01 -> result=8'hFF, carry_out=0.
- Logic ops, a=8'hF0, b=8'h3C: and -> 8'h30; or -> 8'hFC; xor -> 8'hCC. All three give carry_out=0 and overflow=0.
- start held high through RUN with different a/b -> ignored, result matches the first operands. Back-to-back start in DONE is accepted and done recurs 9 cycles later.
- op=3'b111, a=8'hFE(-2), b=8'h01: with ALU_SERIAL_SLT_EN -> result=8'h01, op_err=0. Without it -> result=8'h00, zero_flag=1, op_err=1.

Source files
------------

// File: rtl/alu_serial_seq.sv
// Bit-serial sequential ALU: one operand bit per clock, LSB first, with a registered carry.
// Optional macro ALU_SERIAL_SLT_EN turns op 111 into signed set-less-than.
module alu_serial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero_flag,
    output logic             overflow,
    output logic             op_err
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic             nz_q, nz_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             zero_flag_q, zero_flag_d;
    logic             overflow_q, overflow_d;
    logic             op_err_q, op_err_d;

    logic a_bit, b_bit, sum_bit, cout_bit, res_bit, last_bit, slt_bit;

    function automatic logic op_is_slt(input logic [2:0] o);
`ifdef ALU_SERIAL_SLT_EN
        return (o == OP_SLT);
`else
        return 1'b0;
`endif
    endfunction

    // Ops that run through the adder with B inverted and carry-in of 1.
    function automatic logic op_is_sub(input logic [2:0] o);
        return (o == OP_SUB) || op_is_slt(o);
    endfunction

    function automatic logic op_is_arith(input logic [2:0] o);
        return (o == OP_ADD) || op_is_sub(o);
    endfunction

    function automatic logic op_is_legal(input logic [2:0] o);
        return op_is_arith(o) || (o == OP_AND) || (o == OP_OR) || (o == OP_XOR);
    endfunction

    always_comb begin
        a_bit    = a_sh_q[0];
        b_bit    = b_sh_q[0];
        sum_bit  = a_bit ^ b_bit ^ carry_q;
        cout_bit = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
        // On the MSB cycle carry_q is the carry into the MSB, so N^V needs no extra flop.
        slt_bit  = sum_bit ^ (carry_q ^ cout_bit);

        case (op_q)
            OP_AND:  res_bit = a_bit & b_bit;
            OP_OR:   res_bit = a_bit | b_bit;
            OP_XOR:  res_bit = a_bit ^ b_bit;
            default: res_bit = op_is_arith(op_q) ? sum_bit : 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_sh_d    = res_sh_q;
        op_d        = op_q;
        carry_d     = carry_q;
        nz_d        = nz_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        zero_flag_d = zero_flag_q;
        overflow_d  = overflow_q;
        op_err_d    = op_err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = op_is_sub(op) ? ~b : b;
                    op_d     = op;
                    carry_d  = op_is_sub(op);
                    res_sh_d = '0;
                    nz_d     = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = {res_bit, res_sh_q[WIDTH-1:1]};
                nz_d     = nz_q | res_bit;
                cnt_d    = cnt_q + CNT_W'(1);
                if (op_is_arith(op_q)) begin
                    carry_d = cout_bit;
                end

                // Final bit: commit result and flags together with entry to DONE.
                if (last_bit) begin
                    state_d = S_DONE;
                    if (!op_is_legal(op_q)) begin
                        result_d    = '0;
                        carry_out_d = 1'b0;
                        zero_flag_d = 1'b1;
                        overflow_d  = 1'b0;
                        op_err_d    = 1'b1;
                    end else if (op_is_slt(op_q)) begin
                        result_d    = {{(WIDTH-1){1'b0}}, slt_bit};
                        carry_out_d = 1'b0;
                        zero_flag_d = ~slt_bit;
                        overflow_d  = 1'b0;
                        op_err_d    = 1'b0;
                    end else if (op_is_arith(op_q)) begin
                        result_d    = res_sh_d;
                        carry_out_d = cout_bit;
                        zero_flag_d = ~nz_d;
                        overflow_d  = carry_q ^ cout_bit;
                        op_err_d    = 1'b0;
                    end else begin
                        result_d    = res_sh_d;
                        carry_out_d = 1'b0;
                        zero_flag_d = ~nz_d;
                        overflow_d  = 1'b0;
                        op_err_d    = 1'b0;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            op_q        <= '0;
            carry_q     <= 1'b0;
            nz_q        <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            zero_flag_q <= 1'b0;
            overflow_q  <= 1'b0;
            op_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_sh_q    <= res_sh_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            nz_q        <= nz_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            zero_flag_q <= zero_flag_d;
            overflow_q  <= overflow_d;
            op_err_q    <= op_err_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign zero_flag = zero_flag_q;
    assign overflow  = overflow_q;
    assign op_err    = op_err_q;

endmodule
